// File: rtl/addsub32_pkg.sv
// addsub32_pkg: shared width and opcode constants for the add/subtract core
package addsub32_pkg;
  localparam int WIDTH = 32;
  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_ADD = 2'b01;
  localparam logic [1:0] SEL_SUB = 2'b10;
endpackage

// File: rtl/addsub32_full_adder.sv
// full_adder: one-bit adder cell of the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/addsub32.sv
// addsub32: registered 32-bit add/subtract with carry, zero, overflow and negative flags
module addsub32
  import addsub32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             cin,
  input  logic             bin,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             bout,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);
  logic is_add, is_sub;
  logic [WIDTH-1:0] bx, s;
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] z_d, z_q;
  logic cout_d, bout_d, carry_d, zero_d, ovf_d, neg_d;
  logic cout_q, bout_q, carry_q, zero_q, ovf_q, neg_q;
  assign is_add = sel == SEL_ADD;
  assign is_sub = sel == SEL_SUB;
  // subtract runs as a + ~b + ~bin, so the chain's carry-out is the inverted borrow
  assign bx = is_sub ? ~b : b;
  assign c[0] = is_sub ? ~bin : cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(bx[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  always_comb begin
    z_d = (is_add || is_sub) ? s : '0;
    cout_d = is_add & c[WIDTH];
    bout_d = is_sub & ~c[WIDTH];
    carry_d = cout_d | bout_d;
    ovf_d = is_add ? (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]) :
            is_sub ? (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    zero_d = ~|z_d;
    neg_d = z_d[WIDTH-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
      cout_q <= 1'b0;
      bout_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      z_q <= z_d;
      cout_q <= cout_d;
      bout_q <= bout_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      neg_q <= neg_d;
    end
  end
  assign z = z_q;
  assign cout = cout_q;
  assign bout = bout_q;
  assign carry = carry_q;
  assign zero = zero_q;
  assign overflow = ovf_q;
  assign negative = neg_q;
endmodule

// File: tb/tb_addsub32.sv
// tb_addsub32: directed and random checks of addsub32 against a 33-bit arithmetic model
module tb_addsub32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [1:0] sel = '0;
  logic cin = 1'b0, bin = 1'b0;
  logic [31:0] z;
  logic cout, bout, carry, zero, overflow, negative;
  logic [37:0] got, exp_q;
  logic exp_valid = 1'b0;
  int tests = 0, fails = 0;

  addsub32 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .cin(cin), .bin(bin),
    .z(z), .cout(cout), .bout(bout), .carry(carry), .zero(zero),
    .overflow(overflow), .negative(negative)
  );

  always #5 clk = ~clk;

  assign got = {z, cout, bout, carry, zero, overflow, negative};

  // result vector layout: {z, cout, bout, carry, zero, overflow, negative}
  function automatic logic [37:0] model(input logic [31:0] ma, mb, input logic [1:0] ms,
                                        input logic mc, mbi);
    logic [32:0] r;
    longint sr;
    logic [31:0] mz;
    logic co, bo, ov;
    mz = '0; co = 1'b0; bo = 1'b0; ov = 1'b0;
    if (ms == 2'b01) begin
      r = {1'b0, ma} + {1'b0, mb} + 33'(mc);
      mz = r[31:0];
      co = r[32];
      sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else if (ms == 2'b10) begin
      r = {1'b0, ma} - {1'b0, mb} - 33'(mbi);
      mz = r[31:0];
      bo = r[32];
      sr = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbi);
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    return {mz, co, bo, co | bo, mz == 32'd0, ov, mz[31]};
  endfunction

  task automatic cmp(input string nm, input logic [37:0] act, input logic [37:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got z=%h flags=%b, expected z=%h flags=%b",
               nm, act[37:6], act[5:0], req[37:6], req[5:0]);
    end
  endtask

  always @(posedge clk) begin
    exp_q = rst_n ? model(a, b, sel, cin, bin) : 38'd0;
    exp_valid = 1'b1;
  end

  always @(negedge clk)
    if (exp_valid) cmp("model", got, rst_n ? exp_q : 38'd0);

  task automatic vec(input string nm, input logic [31:0] ta, tb, input logic [1:0] ts,
                     input logic tc, tbi, input logic [31:0] ez, input logic [5:0] ef);
    a = ta; b = tb; sel = ts; cin = tc; bin = tbi;
    @(posedge clk);
    @(negedge clk);
    cmp(nm, got, {ez, ef});
  endtask

  initial begin
    a = 32'hDEADBEEF; b = 32'h12345678; sel = 2'b01; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset", got, 38'd0);
    rst_n = 1'b1;
    // flags: cout bout carry zero overflow negative
    vec("add_1_1", 32'd1, 32'd1, 2'b01, 1'b0, 1'b0, 32'd2, 6'b000000);
    vec("add_wrap", 32'hFFFFFFFF, 32'd0, 2'b01, 1'b1, 1'b0, 32'd0, 6'b101100);
    vec("add_ovf_pos", 32'h7FFFFFFF, 32'd1, 2'b01, 1'b0, 1'b0, 32'h80000000, 6'b000011);
    vec("add_ovf_neg", 32'h80000000, 32'h80000000, 2'b01, 1'b0, 1'b0, 32'd0, 6'b101110);
    vec("sub_borrow", 32'd0, 32'd1, 2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 6'b011001);
    vec("sub_equal", 32'd5, 32'd5, 2'b10, 1'b0, 1'b0, 32'd0, 6'b000100);
    vec("sub_ovf", 32'h80000000, 32'd1, 2'b10, 1'b0, 1'b0, 32'h7FFFFFFF, 6'b000010);
    vec("sub_bin", 32'd10, 32'd3, 2'b10, 1'b0, 1'b1, 32'd6, 6'b000000);
    vec("sub_ign_cin", 32'd10, 32'd3, 2'b10, 1'b1, 1'b0, 32'd7, 6'b000000);
    vec("add_ign_bin", 32'd2, 32'd3, 2'b01, 1'b0, 1'b1, 32'd5, 6'b000000);
    vec("idle_00", 32'd5, 32'd3, 2'b00, 1'b1, 1'b1, 32'd0, 6'b000100);
    vec("idle_11", 32'hFFFFFFFF, 32'd1, 2'b11, 1'b1, 1'b0, 32'd0, 6'b000100);
    vec("sub_ones", 32'd0, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b1, 32'd0, 6'b011100);
    // asynchronous reset mid-cycle must clear the held result without a clock edge
    vec("pre_reset", 32'h7FFFFFFF, 32'd1, 2'b01, 1'b0, 1'b0, 32'h80000000, 6'b000011);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset", got, 38'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post_reset", 32'd1, 32'd1, 2'b01, 1'b0, 1'b0, 32'd2, 6'b000000);
    for (int s = 0; s < 4; s++)
      for (int n = 0; n < 1000; n++) begin
        a = $urandom; b = $urandom; sel = 2'(s);
        cin = 1'($urandom_range(0, 1)); bin = 1'($urandom_range(0, 1));
        if (n % 16 == 0) a = 32'h80000000;
        if (n % 16 == 1) b = a;
        @(posedge clk);
        @(negedge clk);
      end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
